// File: rtl/mul_seq_unit_pkg.sv
// Shared encodings for the sequential RV32M multiplier.
// Optional early-exit sequencing is enabled by FAST_UNSIGNED_EN.
package mul_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int LAT_FIXED = XLEN_DEF + 4;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ABS_A  = 3'd1;
  localparam logic [2:0] ABS_B  = 3'd2;
  localparam logic [2:0] CALC   = 3'd3;
  localparam logic [2:0] NEG_LO = 3'd4;
  localparam logic [2:0] NEG_HI = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

endpackage

// File: rtl/mul_seq_unit_adder.sv
// Plain ripple-carry adder, the only arithmetic resource
// of the sequential multiplier.
module ripple_adder #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] x,
  input  logic [SIZE-1:0] y,
  input  logic            cin,
  output logic [SIZE-1:0] s,
  output logic            cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < SIZE; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Shift-add RV32M multiplier built around one ripple adder.
// FAST_UNSIGNED_EN skips sign-fixup states that have no work.
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

`ifdef FAST_UNSIGNED_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic [2:0]      state;
  logic [1:0]      op_r;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] p_hi;
  logic [XLEN-1:0] p_lo;
  logic [CNT_W-1:0] cnt;
  logic            sa;
  logic            sb;
  logic            neg;
  logic            carry;

  logic [XLEN-1:0] ax;
  logic [XLEN-1:0] ay;
  logic            acin;
  logic [XLEN-1:0] sum;
  logic            cout;

  logic sa_in;
  logic sb_in;

  assign sa_in = a[XLEN-1] && (op == OP_MULH || op == OP_MULHSU);
  assign sb_in = b[XLEN-1] && (op == OP_MULH);

  ripple_adder #(
    .SIZE(XLEN)
  ) u_add (
    .x   (ax),
    .y   (ay),
    .cin (acin),
    .s   (sum),
    .cout(cout)
  );

  // Two's-complement steps reuse the adder as ~v + cin.
  always_comb begin
    ax   = '0;
    ay   = '0;
    acin = 1'b0;
    case (state)
      ABS_A: begin
        ax   = ~mcand;
        acin = 1'b1;
      end
      ABS_B: begin
        ax   = ~p_lo;
        acin = 1'b1;
      end
      CALC: begin
        ax = p_hi;
        ay = p_lo[0] ? mcand : '0;
      end
      NEG_LO: begin
        ax   = ~p_lo;
        acin = 1'b1;
      end
      NEG_HI: begin
        ax   = ~p_hi;
        acin = carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= '0;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r  <= op;
          mcand <= a;
          p_lo  <= b;
          p_hi  <= '0;
          cnt   <= '0;
          sa    <= sa_in;
          sb    <= sb_in;
          neg   <= sa_in ^ sb_in;
          carry <= 1'b0;
          if (!FAST || sa_in)
            state <= ABS_A;
          else if (sb_in)
            state <= ABS_B;
          else
            state <= CALC;
        end
        ABS_A: begin
          if (sa)
            mcand <= sum;
          state <= (FAST && !sb) ? CALC : ABS_B;
        end
        ABS_B: begin
          if (sb)
            p_lo <= sum;
          p_hi  <= '0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          {p_hi, p_lo} <= {cout, sum, p_lo[XLEN-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1))
            state <= (FAST && !neg) ? DONE : NEG_LO;
        end
        NEG_LO: begin
          if (neg) begin
            p_lo  <= sum;
            carry <= cout;
          end else begin
            carry <= 1'b0;
          end
          state <= NEG_HI;
        end
        NEG_HI: begin
          if (neg)
            p_hi <= sum;
          state <= DONE;
        end
        DONE: if (out_ready)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = (state != DONE) ? '0 :
                     (op_r == OP_MUL) ? p_lo : p_hi;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit; honours FAST_UNSIGNED_EN
// when computing the expected latency.
module tb_mul_seq_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int vectors;
  int miscompares;

  mul_seq_unit #(
    .XLEN (32),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    bit s_a;
    bit s_b;
    s_a = x[31] && (o == 2'b01 || o == 2'b10);
    s_b = y[31] && (o == 2'b01);
`ifdef FAST_UNSIGNED_EN
    return 32 + int'(s_a) + int'(s_b) + ((s_a ^ s_b) ? 2 : 0);
`else
    return 36;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, wait for it with junk on the inputs,
  // optionally stall in DONE, then drain it.
  task automatic run(input string tag,
                     input logic [1:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] exp,
                     input bit early,
                     input int hold);
    int n;
    int lat;
    lat = exp_lat(o, x, y);
    chk({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    n = 0;
    while (!out_valid && n < 200) begin
      in_valid  = n[0];
      op        = n[1:0];
      a         = $urandom;
      b         = $urandom;
      out_ready = early;
      step();
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = $urandom;
      step();
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_result"}, result, exp);
      chk({tag, "_hold_busy"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    step();

    run("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 1'b0, 0);
    run("mul_12345", 2'b00, 32'h0001_2345, 32'h0001_0000,
        32'h2345_0000, 1'b1, 0);
    run("mulh_12345", 2'b01, 32'h0001_2345, 32'h0001_0000,
        32'h0000_0001, 1'b0, 0);
    run("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 1'b0, 0);
    run("mulh_m1x5", 2'b01, 32'hFFFF_FFFF, 32'h0000_0005,
        32'hFFFF_FFFF, 1'b0, 0);
    run("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 1'b0, 10);
    run("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0001, 1'b0, 0);
    run("mulh_neg0", 2'b01, 32'hFFFF_FFFF, 32'h0000_0000,
        32'h0000_0000, 1'b0, 0);

    // Abort mid-CALC.
    op = 2'b01;
    a = 32'h1234_5678;
    b = 32'h8765_4321;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("abort_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);

    run("mulhu_3x5", 2'b11, 32'd3, 32'd5, 32'd0, 1'b0, 0);
    run("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
- Multi-cycle RV32M multiplier for the MUL/MULH/MULHSU/MULHU datapath.
- Reuses a single 32-bit ripple adder, instantiated once internally, and sequences it over many cycles using shift-add.
- Sits beside the ALU in the execute stage and talks to the pipeline through a valid/ready handshake.

Parameters:
- XLEN, default 32: operand width and the adder's SIZE parameter.
- CNT_W, default 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands and op are valid.
- in_ready, output, 1: unit is idle and can accept.
- op, input, 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- a, input, XLEN: rs1 operand.
- b, input, XLEN: rs2 operand.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, XLEN: product word.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, internal registers=0.
- Reset in any state aborts the operation with no result; it has priority over every other input.
- Accept: in_valid && in_ready on a clock edge. At that edge latch op, a, b and compute:
  - sa = a[XLEN-1] && (op==01 || op==10)
  - sb = b[XLEN-1] && (op==01)
  - neg = sa ^ sb
- op 00 is treated as unsigned; its low word is identical either way.
- States: IDLE -> ABS_A -> ABS_B -> CALC -> NEG_LO -> NEG_HI -> DONE -> IDLE.
- The single adder is the only arithmetic resource; each state drives its X, Y and Cin as below.
- ABS_A: if sa, mcand = ~a + 1 (X=~a, Y=0, Cin=1); otherwise mcand = a.
- ABS_B: if sb, P_lo = ~b + 1; otherwise P_lo = b. P_hi = 0. cnt = 0.
- CALC, one iteration per cycle, XLEN cycles total:
  - X = P_hi, Y = P_lo[0] ? mcand : 0, Cin = 0.
  - {P_hi, P_lo} <= {Cout, S, P_lo} >> 1.
  - cnt increments; leave CALC when cnt == XLEN-1.
- NEG_LO: if neg, P_lo <= ~P_lo + 1 and the adder Cout is saved to carry; otherwise carry = 0 and P_lo is unchanged.
- NEG_HI: if neg, P_hi <= ~P_hi + carry; otherwise unchanged.
- DONE: out_valid=1 and result = (op==00) ? P_lo : P_hi.
  - result and out_valid are held stable until out_ready.
  - On the edge where out_valid && out_ready, go to IDLE; in_ready rises in the next cycle. There is no back-to-back accept in the same edge.
- Latency: out_valid rises exactly XLEN+4 = 36 edges after the accepting edge. This is fixed, independent of the operands.
- While not IDLE: in_ready=0, and in_valid and operand changes are ignored.
- Boundaries:
  - a = 0x80000000 with sa: ~a + 1 wraps to 0x80000000, which is correct as unsigned magnitude 2^31.
  - Operand 0: runs the full latency and gives result 0. If neg and the product is 0, negation yields 0; carry propagates into P_hi.
  - out_ready held high before DONE: no effect.

Optional Feature:
- Macro FAST_UNSIGNED_EN.
- Defined:
  - ABS_A is skipped when sa=0.
  - ABS_B is skipped when sb=0 (P_hi, P_lo and cnt are initialised in the accept edge instead).
  - NEG_LO and NEG_HI are skipped when neg=0.
  - Latency becomes 32 + (sa?1:0) + (sb?1:0) + (neg?2:0) edges; MULHU gives 32.
- Undefined: fixed 36-edge latency as above.
- Results are identical in both builds.

Decomposition:
- Package mul_pkg holds:
  - op encodings OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU;
  - state enum (IDLE, ABS_A, ABS_B, CALC, NEG_LO, NEG_HI, DONE);
  - constant LAT_FIXED = XLEN+4.
- Sub-module: the existing adder with SIZE=XLEN, instantiated once.
- The FSM, muxing and registers stay in mul_seq_unit.

Test Plan:
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE; out_valid exactly 36 edges after accept (32 with FAST_UNSIGNED_EN).
- MUL a=0x00012345, b=0x00010000 -> result 0x23450000; MULH with the same operands -> 0x00000001.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULH a=0xFFFFFFFF(-1), b=0x00000005 -> 0xFFFFFFFF.
- MULHSU a=0xFFFFFFFF(-1), b=0xFFFFFFFF(unsigned) -> 0xFFFFFFFF; MUL with the same operands -> 0x00000001.
- Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; then pulse out_ready -> in_ready=1 next cycle. Toggling in_valid during busy is ignored.
- Assert rst in cycle 15 of CALC -> next cycle in_ready=1, out_valid=0, result=0. A new MULHU 3*5 then returns 0x00000000, and MUL 3*5 returns 0x0000000F.
